// File: rtl/latency_bank_pkg.sv
// ---------------------------------------------------------------------------
// latency_bank_pkg
//   Shared constants and types for the latency bank array.
//   - Def* constants : default parameter values for latency_bank and
//                      latency_bank_array.
//   - cnt_t          : 32-bit statistics counter type.
//   - bank_resp_t    : read response word (data + requester tag) at default
//                      widths. Banks built with other widths declare the
//                      same layout locally from their own parameters.
// ---------------------------------------------------------------------------
package latency_bank_pkg;

    localparam int unsigned DefNumBanks     = 16;
    localparam int unsigned DefDataWidth    = 32;
    localparam int unsigned DefMemAddrBits  = 8;
    localparam int unsigned DefIniAddrWidth = 4;
    localparam int unsigned DefLatency      = 1;
    localparam int unsigned DefRespDepth    = 2;

    localparam int unsigned CntWidth = 32;

    typedef logic [CntWidth-1:0] cnt_t;

    typedef struct packed {
        logic [DefDataWidth-1:0]    data;
        logic [DefIniAddrWidth-1:0] tag;
    } bank_resp_t;

endpackage

// File: rtl/latency_bank.sv
// ---------------------------------------------------------------------------
// latency_bank
//   One memory bank: word array with byte-enable writes, a fixed-latency read
//   pipeline, an in-order response FIFO and a credit counter that limits the
//   number of reads in flight to RespDepth.
//
//   Optional feature: define BANK_STATS_EN to build saturating read / write /
//   stall counters; otherwise the statistics outputs are constant 0.
//
//   Ports
//     clk_i, rst_ni          clock, synchronous active-low reset
//     req_i / gnt_o          request and grant (transfer when both high)
//     add_i, wen_i           word address, 1 = write / 0 = read
//     wdata_i, be_i          write data and byte enables
//     ini_add_i              requester tag, returned with read data
//     vld_o / rdy_i          read response handshake
//     rdata_o, ini_add_o     response data and tag
//     read_cnt_o, write_cnt_o, stall_cnt_o  statistics
// ---------------------------------------------------------------------------
module latency_bank
    import latency_bank_pkg::*;
#(
    parameter int unsigned DataWidth    = DefDataWidth,
    parameter int unsigned MemAddrBits  = DefMemAddrBits,
    parameter int unsigned IniAddrWidth = DefIniAddrWidth,
    parameter int unsigned Latency      = DefLatency,
    parameter int unsigned RespDepth    = DefRespDepth
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [MemAddrBits-1:0]  add_i,
    input  logic                    wen_i,
    input  logic [DataWidth-1:0]    wdata_i,
    input  logic [DataWidth/8-1:0]  be_i,
    input  logic [IniAddrWidth-1:0] ini_add_i,
    output logic                    vld_o,
    input  logic                    rdy_i,
    output logic [DataWidth-1:0]    rdata_o,
    output logic [IniAddrWidth-1:0] ini_add_o,
    output cnt_t                    read_cnt_o,
    output cnt_t                    write_cnt_o,
    output cnt_t                    stall_cnt_o
);

    localparam int unsigned NumWords = 2 ** MemAddrBits;
    localparam int unsigned NumBytes = DataWidth / 8;
    localparam int unsigned CredW    = $clog2(RespDepth + 1);
    localparam int unsigned PtrW     = (RespDepth > 1) ? $clog2(RespDepth) : 1;

    typedef struct packed {
        logic [DataWidth-1:0]    data;
        logic [IniAddrWidth-1:0] tag;
    } resp_t;

    function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
        return (p == PtrW'(RespDepth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    logic [DataWidth-1:0] mem_q [NumWords];

    logic             rd_gnt;
    logic             wr_gnt;
    logic [CredW-1:0] outstanding_q;

    logic             rd_vld_p [Latency];
    resp_t            rd_rsp_p [Latency];

    resp_t            fifo_q [RespDepth];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CredW-1:0] fifo_cnt_q;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic             pipe_vld;
    resp_t            pipe_rsp;
    resp_t            head_rsp;
    logic             rsp_take;

    // Grant decision: writes always pass, reads need a free response credit.
    // Only registered credit state is used, so rdy_i never reaches gnt_o.
    assign wr_gnt = rst_ni && req_i && wen_i;
    assign rd_gnt = rst_ni && req_i && !wen_i && (outstanding_q < CredW'(RespDepth));
    assign gnt_o  = wr_gnt || rd_gnt;

    // ---- array write (lands at the grant edge, visible to the next read) ----
    always_ff @(posedge clk_i) begin
        if (wr_gnt) begin
            for (int b = 0; b < NumBytes; b++) begin
                if (be_i[b]) begin
                    mem_q[add_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    // ---- stage p0: array sampled in the grant cycle; p1.. shift it down ----
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < Latency; i++) begin
                rd_vld_p[i] <= 1'b0;
            end
        end else begin
            rd_vld_p[0] <= rd_gnt;
            for (int i = 1; i < Latency; i++) begin
                rd_vld_p[i] <= rd_vld_p[i-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rd_gnt) begin
            rd_rsp_p[0] <= '{data: mem_q[add_i], tag: ini_add_i};
        end
        for (int i = 1; i < Latency; i++) begin
            rd_rsp_p[i] <= rd_rsp_p[i-1];
        end
    end

    assign pipe_vld = rd_vld_p[Latency-1];
    assign pipe_rsp = rd_rsp_p[Latency-1];

    // ---- response stage: FIFO with bypass ----
    // A response leaving the pipeline goes straight to the output when the
    // FIFO is empty and the consumer is ready; otherwise it queues behind
    // older responses. FIFO entries are always older than the pipeline head,
    // so presenting the FIFO head first keeps grant order. The credit limit
    // guarantees the FIFO never overflows.
    assign fifo_empty = (fifo_cnt_q == '0);
    assign head_rsp   = fifo_empty ? pipe_rsp : fifo_q[rd_ptr_q];
    assign vld_o      = rst_ni && (!fifo_empty || pipe_vld);
    assign rdata_o    = head_rsp.data;
    assign ini_add_o  = head_rsp.tag;
    assign rsp_take   = vld_o && rdy_i;
    assign fifo_pop   = !fifo_empty && rdy_i;
    assign fifo_push  = pipe_vld && !(fifo_empty && rdy_i);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr_q <= ptr_next(wr_ptr_q);
            end
            if (fifo_pop) begin
                rd_ptr_q <= ptr_next(rd_ptr_q);
            end
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CredW'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CredW'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (fifo_push) begin
            fifo_q[wr_ptr_q] <= pipe_rsp;
        end
    end

    // Credits: reads in the pipeline plus responses waiting in the FIFO.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            outstanding_q <= '0;
        end else begin
            case ({rd_gnt, rsp_take})
                2'b10:   outstanding_q <= outstanding_q + CredW'(1);
                2'b01:   outstanding_q <= outstanding_q - CredW'(1);
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

`ifdef BANK_STATS_EN
    function automatic cnt_t sat_inc(input cnt_t c);
        return (c == '1) ? c : c + cnt_t'(1);
    endfunction

    cnt_t read_cnt_q;
    cnt_t write_cnt_q;
    cnt_t stall_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            read_cnt_q  <= '0;
            write_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (rd_gnt) begin
                read_cnt_q <= sat_inc(read_cnt_q);
            end
            if (wr_gnt) begin
                write_cnt_q <= sat_inc(write_cnt_q);
            end
            if (req_i && !gnt_o) begin
                stall_cnt_q <= sat_inc(stall_cnt_q);
            end
        end
    end

    assign read_cnt_o  = read_cnt_q;
    assign write_cnt_o = write_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`else
    assign read_cnt_o  = '0;
    assign write_cnt_o = '0;
    assign stall_cnt_o = '0;
`endif

endmodule

// File: rtl/latency_bank_array.sv
// ---------------------------------------------------------------------------
// latency_bank_array
//   NumBanks fully independent latency_bank instances. Every port is a
//   per-bank vector; bank g uses slice [g] of each.
//
//   Optional feature: define BANK_STATS_EN to enable the per-bank saturating
//   statistics counters; otherwise the statistics outputs are tied to 0.
//
//   Ports
//     clk_i, rst_ni              clock, synchronous active-low reset
//     req_i / gnt_o              per-bank request / grant
//     add_i, wen_i, wdata_i, be_i  address, write select, data, byte enables
//     ini_add_i                  requester tag in
//     vld_o / rdy_i              per-bank response handshake
//     rdata_o, ini_add_o         response data and returned tag
//     read_cnt_o, write_cnt_o, stall_cnt_o  per-bank statistics
// ---------------------------------------------------------------------------
module latency_bank_array
    import latency_bank_pkg::*;
#(
    parameter int unsigned NumBanks     = DefNumBanks,
    parameter int unsigned DataWidth    = DefDataWidth,
    parameter int unsigned MemAddrBits  = DefMemAddrBits,
    parameter int unsigned IniAddrWidth = DefIniAddrWidth,
    parameter int unsigned Latency      = DefLatency,
    parameter int unsigned RespDepth    = DefRespDepth
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [NumBanks-1:0]                    req_i,
    output logic [NumBanks-1:0]                    gnt_o,
    input  logic [NumBanks-1:0][MemAddrBits-1:0]   add_i,
    input  logic [NumBanks-1:0]                    wen_i,
    input  logic [NumBanks-1:0][DataWidth-1:0]     wdata_i,
    input  logic [NumBanks-1:0][DataWidth/8-1:0]   be_i,
    input  logic [NumBanks-1:0][IniAddrWidth-1:0]  ini_add_i,
    output logic [NumBanks-1:0]                    vld_o,
    input  logic [NumBanks-1:0]                    rdy_i,
    output logic [NumBanks-1:0][DataWidth-1:0]     rdata_o,
    output logic [NumBanks-1:0][IniAddrWidth-1:0]  ini_add_o,
    output logic [NumBanks-1:0][CntWidth-1:0]      read_cnt_o,
    output logic [NumBanks-1:0][CntWidth-1:0]      write_cnt_o,
    output logic [NumBanks-1:0][CntWidth-1:0]      stall_cnt_o
);

    for (genvar g = 0; g < NumBanks; g++) begin : g_bank
        latency_bank #(
            .DataWidth    (DataWidth),
            .MemAddrBits  (MemAddrBits),
            .IniAddrWidth (IniAddrWidth),
            .Latency      (Latency),
            .RespDepth    (RespDepth)
        ) u_bank (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .req_i       (req_i[g]),
            .gnt_o       (gnt_o[g]),
            .add_i       (add_i[g]),
            .wen_i       (wen_i[g]),
            .wdata_i     (wdata_i[g]),
            .be_i        (be_i[g]),
            .ini_add_i   (ini_add_i[g]),
            .vld_o       (vld_o[g]),
            .rdy_i       (rdy_i[g]),
            .rdata_o     (rdata_o[g]),
            .ini_add_o   (ini_add_o[g]),
            .read_cnt_o  (read_cnt_o[g]),
            .write_cnt_o (write_cnt_o[g]),
            .stall_cnt_o (stall_cnt_o[g])
        );
    end

endmodule

// File: tb/tb_latency_bank_array.sv
// ---------------------------------------------------------------------------
// tb_latency_bank_array
//   Two array instances: A (4 banks, Latency 1, RespDepth 2) exercised with
//   directed scenarios and random traffic against a transaction-level model;
//   B (1 bank, Latency 3, RespDepth 4) for back-to-back read throughput.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_latency_bank_array;

    localparam int NB    = 4;
    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int TW    = 4;
    localparam int LAT   = 1;
    localparam int DEP   = 2;
    localparam int LAT_B = 3;
    localparam int DEP_B = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [NB-1:0]          req, gnt, wen, vld, rdy;
    logic [NB-1:0][AW-1:0]  add;
    logic [NB-1:0][DW-1:0]  wdata, rdata;
    logic [NB-1:0][DW/8-1:0] be;
    logic [NB-1:0][TW-1:0]  tag_in, tag_out;
    logic [NB-1:0][31:0]    rcnt, wcnt, scnt;

    logic [0:0]             b_req, b_gnt, b_wen, b_vld, b_rdy;
    logic [0:0][AW-1:0]     b_add;
    logic [0:0][DW-1:0]     b_wdata, b_rdata;
    logic [0:0][DW/8-1:0]   b_be;
    logic [0:0][TW-1:0]     b_tag_in, b_tag_out;
    logic [0:0][31:0]       b_rcnt, b_wcnt, b_scnt;

    latency_bank_array #(
        .NumBanks(NB), .DataWidth(DW), .MemAddrBits(AW), .IniAddrWidth(TW),
        .Latency(LAT), .RespDepth(DEP)
    ) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .add_i(add),
        .wen_i(wen), .wdata_i(wdata), .be_i(be), .ini_add_i(tag_in),
        .vld_o(vld), .rdy_i(rdy), .rdata_o(rdata), .ini_add_o(tag_out),
        .read_cnt_o(rcnt), .write_cnt_o(wcnt), .stall_cnt_o(scnt)
    );

    latency_bank_array #(
        .NumBanks(1), .DataWidth(DW), .MemAddrBits(AW), .IniAddrWidth(TW),
        .Latency(LAT_B), .RespDepth(DEP_B)
    ) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .req_i(b_req), .gnt_o(b_gnt), .add_i(b_add),
        .wen_i(b_wen), .wdata_i(b_wdata), .be_i(b_be), .ini_add_i(b_tag_in),
        .vld_o(b_vld), .rdy_i(b_rdy), .rdata_o(b_rdata), .ini_add_o(b_tag_out),
        .read_cnt_o(b_rcnt), .write_cnt_o(b_wcnt), .stall_cnt_o(b_scnt)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Reference model: per bank, the memory image, the ordered list of reads
    // still owed a response (with the cycle they become presentable), and
    // the statistics totals.
    typedef struct packed {
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
        int            due;
    } exp_t;

    exp_t          exp_q   [NB][$];
    logic [DW-1:0] mdl_mem [NB][256];
    int            m_rd [NB];
    int            m_wr [NB];
    int            m_st [NB];
    int            cyc = 0;
    logic [NB-1:0] gnt_seen;

    function automatic logic [31:0] stat_exp(input int v);
`ifdef BANK_STATS_EN
        return 32'(v);
`else
        return 32'(v) & 32'd0;
`endif
    endfunction

    task automatic idle(input logic [NB-1:0] r);
        req = '0; wen = '0; add = '0; wdata = '0; be = '0; tag_in = '0; rdy = r;
    endtask

    // One clock of instance A: inputs already driven; compare at negedge,
    // advance the model, return 1ns after the next posedge.
    task automatic cycle();
        logic eg, ev;
        @(negedge clk);
        gnt_seen = gnt;
        for (int b = 0; b < NB; b++) begin
            eg = rst_n && req[b] && (wen[b] || exp_q[b].size() < DEP);
            ev = rst_n && exp_q[b].size() > 0 && exp_q[b][0].due <= cyc;
            chk($sformatf("gnt[%0d]@%0d", b, cyc), 64'(gnt[b]), 64'(eg));
            chk($sformatf("vld[%0d]@%0d", b, cyc), 64'(vld[b]), 64'(ev));
            if (ev && vld[b]) begin
                chk($sformatf("rdata[%0d]@%0d", b, cyc), 64'(rdata[b]), 64'(exp_q[b][0].data));
                chk($sformatf("tag[%0d]@%0d", b, cyc), 64'(tag_out[b]), 64'(exp_q[b][0].tag));
            end
            chk($sformatf("rd_cnt[%0d]@%0d", b, cyc), 64'(rcnt[b]), 64'(stat_exp(m_rd[b])));
            chk($sformatf("wr_cnt[%0d]@%0d", b, cyc), 64'(wcnt[b]), 64'(stat_exp(m_wr[b])));
            chk($sformatf("st_cnt[%0d]@%0d", b, cyc), 64'(scnt[b]), 64'(stat_exp(m_st[b])));
            if (!rst_n) begin
                exp_q[b].delete();
                m_rd[b] = 0; m_wr[b] = 0; m_st[b] = 0;
            end else begin
                if (ev && rdy[b]) void'(exp_q[b].pop_front());
                if (eg && wen[b]) begin
                    for (int k = 0; k < DW/8; k++)
                        if (be[b][k]) mdl_mem[b][add[b]][k*8 +: 8] = wdata[b][k*8 +: 8];
                    m_wr[b]++;
                end else if (eg) begin
                    exp_q[b].push_back('{data: mdl_mem[b][add[b]], tag: tag_in[b], due: cyc + LAT});
                    m_rd[b]++;
                end
                if (req[b] && !eg) m_st[b]++;
            end
        end
        cyc++;
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int            gcount;
        logic [DW-1:0] bm [8];
        exp_t          bq [$];
        exp_t          e;
        int            bg, first_g, first_v;

        for (int b = 0; b < NB; b++) begin m_rd[b] = 0; m_wr[b] = 0; m_st[b] = 0; end
        rst_n = 1'b0;
        idle('0);
        b_req = '0; b_wen = '0; b_add = '0; b_wdata = '0; b_be = '0; b_tag_in = '0; b_rdy = '1;
        repeat (3) @(posedge clk);
        #1;

        // Reset state with requests pending: no grants, no responses.
        idle('1); req = '1;
        cycle();
        rst_n = 1'b1;

        // Initialise the address window used by all tests.
        for (int a = 16; a < 32; a++) begin
            idle('1);
            for (int b = 0; b < NB; b++) begin
                req[b] = 1'b1; wen[b] = 1'b1; add[b] = AW'(a); wdata[b] = $urandom; be[b] = '1;
            end
            cycle();
        end

        // Write then immediate read, tag returned after one cycle.
        idle('1); req[3] = 1; wen[3] = 1; add[3] = 8'h10; wdata[3] = 32'hDEADBEEF; be[3] = 4'hF;
        cycle();
        idle('1); req[3] = 1; add[3] = 8'h10; tag_in[3] = 4'd5;
        cycle();
        chk("wr_rd_vld", 64'(vld[3]), 64'd1);
        chk("wr_rd_data", 64'(rdata[3]), 64'hDEADBEEF);
        chk("wr_rd_tag", 64'(tag_out[3]), 64'd5);
        idle('1); cycle();

        // Partial byte-enable write merges with existing word.
        idle('1); req[1] = 1; wen[1] = 1; add[1] = 8'h12; wdata[1] = 32'h11223344; be[1] = 4'hF;
        cycle();
        idle('1); req[1] = 1; wen[1] = 1; add[1] = 8'h12; wdata[1] = 32'hAABBCCDD; be[1] = 4'b0101;
        cycle();
        idle('1); req[1] = 1; add[1] = 8'h12; tag_in[1] = 4'd9;
        cycle();
        chk("be_merge_data", 64'(rdata[1]), 64'h11BB33DD);
        idle('1); cycle();

        // Credit exhaustion with the consumer stalled, then in-order drain.
        gcount = 0;
        for (int k = 0; k < 6; k++) begin
            idle('0); req[2] = 1; add[2] = AW'(16 + k); tag_in[2] = TW'(k);
            cycle();
            gcount += int'(gnt_seen[2]);
        end
        chk("credit_grants", 64'(gcount), 64'd2);
        chk("credit_last_gnt", 64'(gnt_seen[2]), 64'd0);
        chk("drain_first_tag", 64'(tag_out[2]), 64'd0);
        idle('1);
        repeat (3) cycle();

        // Reset with two reads in flight: responses dropped, data kept.
        idle('0); req[0] = 1; add[0] = 8'h10; tag_in[0] = 4'd1; cycle();
        idle('0); req[0] = 1; add[0] = 8'h11; tag_in[0] = 4'd2; cycle();
        rst_n = 1'b0; idle('1); req = '1; cycle();
        rst_n = 1'b1; idle('1);
        repeat (3) cycle();
        chk("rst_no_vld", 64'(vld[0]), 64'd0);
        chk("rst_rd_cnt", 64'(rcnt[0]), 64'd0);
        idle('1); req[3] = 1; add[3] = 8'h10; tag_in[3] = 4'd7;
        cycle();
        chk("rst_keep_data", 64'(rdata[3]), 64'hDEADBEEF);
        idle('1); cycle();

        // Random traffic with a stalled-consumer phase and one reset.
        for (int i = 0; i < 800; i++) begin
            rst_n = (i != 500);
            for (int b = 0; b < NB; b++) begin
                req[b]    = ($urandom_range(9) < 6);
                wen[b]    = ($urandom_range(9) < 4);
                add[b]    = 8'h10 + AW'($urandom_range(15));
                wdata[b]  = $urandom;
                be[b]     = 4'($urandom);
                tag_in[b] = 4'($urandom);
                rdy[b]    = (((i / 100) % 3) == 1) ? ($urandom_range(9) < 2) : ($urandom_range(9) < 7);
            end
            cycle();
        end
        rst_n = 1'b1;
        idle('1);
        repeat (4) cycle();

        // Instance B: one read per cycle at Latency 3 with RespDepth 4.
        for (int i = 0; i < 8; i++) begin
            bm[i] = 32'hC0DE0000 + 32'(i) * 32'h111;
            b_req = 1; b_wen = 1; b_add = AW'(i); b_wdata = bm[i]; b_be = '1; b_rdy = 1;
            @(posedge clk); #1;
        end
        bg = 0; first_g = -1; first_v = -1;
        for (int i = 0; i < 110; i++) begin
            b_wen = 0; b_rdy = 1;
            if (i < 100) begin
                b_req = 1; b_add = AW'(i % 8); b_tag_in = TW'(i % 16);
            end else begin
                b_req = 0;
            end
            @(negedge clk);
            if (b_vld[0]) begin
                if (first_v < 0) first_v = i;
                if (bq.size() == 0) begin
                    chk("b_vld_unexpected", 64'(b_vld[0]), 64'd0);
                end else begin
                    e = bq.pop_front();
                    chk($sformatf("b_rdata@%0d", i), 64'(b_rdata[0]), 64'(e.data));
                    chk($sformatf("b_tag@%0d", i), 64'(b_tag_out[0]), 64'(e.tag));
                end
            end
            if (b_req[0] && b_gnt[0]) begin
                bg++;
                if (first_g < 0) first_g = i;
                bq.push_back('{data: bm[i % 8], tag: TW'(i % 16), due: 0});
            end
            @(posedge clk); #1;
        end
        chk("b_grants", 64'(bg), 64'd100);
        chk("b_first_latency", 64'(first_v - first_g), 64'(LAT_B));
        chk("b_all_returned", 64'(bq.size()), 64'd0);
        chk("b_rd_cnt", 64'(b_rcnt[0]), 64'(stat_exp(100)));
        chk("b_wr_cnt", 64'(b_wcnt[0]), 64'(stat_exp(8)));
        chk("b_st_cnt", 64'(b_scnt[0]), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/latency_bank_array.md
LATENCY_BANK_ARRAY -- requirements
Module: latency_bank_array

Interface
REQ-001 The block SHALL have one clock, clk_i; reset rst_ni SHALL be synchronous and active-low.
REQ-002 Parameters SHALL be: NumBanks, default 16, bank count; DataWidth, default 32, word width, multiple of 8; MemAddrBits, default 8, words per bank = 2**MemAddrBits; IniAddrWidth, default 4, initiator tag width; Latency, default 1, read latency ≥1; RespDepth, default 2, per-bank response credits ≥1.
REQ-003 clk_i  in  1  clock.
REQ-004 rst_ni  in  1  synchronous active-low reset.
REQ-005 req_i  in  [NumBanks]  bank request.
REQ-006 gnt_o  out  [NumBanks]  bank grant.
REQ-007 add_i  in  [NumBanks][MemAddrBits]  word address within bank.
REQ-008 wen_i  in  [NumBanks]  1 = write, 0 = read.
REQ-009 wdata_i  in  [NumBanks][DataWidth]  write data.
REQ-010 be_i  in  [NumBanks][DataWidth/8]  byte enables.
REQ-011 ini_add_i  in  [NumBanks][IniAddrWidth]  requester tag, returned with read data.
REQ-012 vld_o  out  [NumBanks]  read response valid.
REQ-013 rdy_i  in  [NumBanks]  response ready.
REQ-014 rdata_o  out  [NumBanks][DataWidth]  read data.
REQ-015 ini_add_o  out  [NumBanks][IniAddrWidth]  returned tag.
REQ-016 read_cnt_o, write_cnt_o, stall_cnt_o  out  [NumBanks][32]  per-bank statistics.

Function
REQ-017 Banks SHALL be fully independent; all rules below apply per bank.
REQ-018 A transfer SHALL occur in a cycle with req_i && gnt_o; gnt_o SHALL be combinational from req_i, wen_i and registered state only, never from rdy_i.
REQ-019 Writes SHALL always be granted; granted byte lanes with be_i set SHALL update at the next edge; writes produce no response.
REQ-020 Reads SHALL be granted only when outstanding < RespDepth; outstanding = reads in the latency pipeline plus entries in the response FIFO.
REQ-021 Read data SHALL be sampled from the array in the grant cycle; a write granted in cycle t SHALL be visible to a read granted in t+1.
REQ-022 A read granted in cycle t SHALL present vld_o no earlier than t+Latency, exactly at t+Latency if the FIFO is empty and rdy_i was high.
REQ-023 Responses SHALL leave in grant order; while vld_o && !rdy_i, rdata_o and ini_add_o SHALL hold stable.
REQ-024 outstanding SHALL increment on read grant, decrement on vld_o && rdy_i, and stay unchanged when both occur in the same cycle; it SHALL never exceed RespDepth.
REQ-025 With RespDepth ≥ Latency+1 and rdy_i held high, a bank SHALL sustain one read per cycle.
REQ-026 rdata_o and ini_add_o SHALL be don't-care when vld_o is low.

Reset
REQ-027 During reset: gnt_o = 0, vld_o = 0, outstanding = 0, pipeline and FIFOs empty, all counters = 0.
REQ-028 Reset asserted mid-operation SHALL discard in-flight reads without a response; array contents SHALL be unaffected by reset.

Configuration
REQ-029 With BANK_STATS_EN defined: read_cnt_o and write_cnt_o SHALL count granted reads and writes; stall_cnt_o SHALL count cycles with req_i && !gnt_o; all SHALL saturate at 2**32-1.
REQ-030 Without BANK_STATS_EN, the statistics ports SHALL exist and be tied to 0, with no counter flops.

Structure
REQ-031 Package latency_bank_pkg SHALL hold the default parameter constants, the per-bank response struct (data, tag) and the 32-bit counter type.
REQ-032 One sub-module, latency_bank, SHALL implement a single bank (array, latency pipeline, response FIFO, credit counter, counters); the top SHALL generate NumBanks instances.

Verification
REQ-033 Latency=1, RespDepth=2, rdy_i=1: write 0xDEADBEEF to bank 3 address 0x10, read next cycle with tag 5 -> vld_o[3] one cycle after grant, rdata_o=0xDEADBEEF, ini_add_o=5.
REQ-034 Latency=3, RespDepth=4, rdy_i=1, 100 back-to-back reads on bank 0 -> 100 grants in 100 cycles, first vld_o 3 cycles after first grant.
REQ-035 RespDepth=2, rdy_i=0, continuous reads -> exactly 2 grants, then gnt_o=0; with BANK_STATS_EN, stall_cnt_o increments each cycle; raising rdy_i drains in order.
REQ-036 be_i=4'b0101 write of 0xAABBCCDD over 0x11223344 -> read returns 0x11BB33DD.
REQ-037 Assert rst_ni for one cycle with 2 reads in flight -> no vld_o afterward, outstanding=0, counters=0, previously written data still readable.
REQ-038 Build without BANK_STATS_EN, random traffic -> all statistics outputs constantly 0, data behaviour identical to REQ-033..036.
